// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_DVD_W = 16;
    localparam int unsigned DIV_DVS_W = 8;

    // Iteration counter must hold values 0..w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(DIV_DVD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor and emit the resulting quotient bit.
module div_step #(
    parameter int unsigned DVS_W = 8
) (
    input  logic [DVS_W-1:0] rem_i,
    input  logic             q_bit_i,
    input  logic [DVS_W-1:0] dvs_i,
    output logic [DVS_W-1:0] rem_o,
    output logic             q_o
);

    logic [DVS_W:0] p;
    logic [DVS_W:0] diff;

    always_comb begin
        p     = {rem_i, q_bit_i};
        diff  = p - {1'b0, dvs_i};
        rem_o = p[DVS_W-1:0];
        q_o   = 1'b0;
        if (p >= {1'b0, dvs_i}) begin
            rem_o = diff[DVS_W-1:0];
            q_o   = 1'b1;
        end
    end

endmodule

// File: rtl/seq_div_16by8.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional SEQ_DIV_EARLY_ZERO_EN: zero divisor completes directly from accept.
module seq_div_16by8
    import div_pkg::*;
#(
    parameter int unsigned DVD_W = DIV_DVD_W,
    parameter int unsigned DVS_W = DIV_DVS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CNT_W = cnt_width(DVD_W);

    div_state_e       state_q, state_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVD_W-1:0] qreg_q, qreg_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DVD_W-1:0] quot_q, quot_d;
    logic [DVS_W-1:0] remo_q, remo_d;
    logic             dz_q, dz_d;

    logic [DVS_W-1:0] step_rem;
    logic             step_q;

    div_step #(.DVS_W(DVS_W)) u_step (
        .rem_i   (rem_q),
        .q_bit_i (qreg_q[DVD_W-1]),
        .dvs_i   (dvs_q),
        .rem_o   (step_rem),
        .q_o     (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvs_q   <= '0;
            qreg_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvs_q   <= dvs_d;
            qreg_q  <= qreg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvs_d   = dvs_q;
        qreg_d  = qreg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dz_d    = dz_q;

        case (state_q)
            RUN: begin
                qreg_d = {qreg_q[DVD_W-2:0], step_q};
                rem_d  = step_rem;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last iteration: publish the freshly computed step directly.
                if (cnt_q == CNT_W'(DVD_W - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = {qreg_q[DVD_W-2:0], step_q};
                    remo_d  = step_rem;
                    dz_d    = (dvs_q == '0);
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    dvs_d   = divisor;
                    qreg_d  = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
`ifdef SEQ_DIV_EARLY_ZERO_EN
                    if (divisor == '0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        remo_d  = dividend[DVS_W-1:0];
                        dz_d    = 1'b1;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Randomized self-checking bench for seq_div_16by8 against an arithmetic model.
`timescale 1ns/1ps
module tb_seq_div_16by8;

    localparam int unsigned DVD_W = 16;
    localparam int unsigned DVS_W = 8;
`ifdef SEQ_DIV_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DVD_W-1:0] hold_q = '0;
    logic [DVS_W-1:0] hold_r = '0;

    seq_div_16by8 #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE/DONE, checked against plain arithmetic.
    task automatic do_op(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
        logic [DVD_W-1:0] eq;
        logic [DVS_W-1:0] er;
        logic             ez;
        int               elat, ebusy, lat, nbusy;
        bit               seen;
        ez    = (b == '0);
        eq    = ez ? '1 : DVD_W'(a / b);
        er    = ez ? a[DVS_W-1:0] : DVS_W'(a % b);
        elat  = (ez && EARLY) ? 1 : DVD_W + 1;
        ebusy = (ez && EARLY) ? 0 : DVD_W;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = DVD_W'($urandom);
        divisor  = DVS_W'($urandom);
        lat   = 1;
        nbusy = 0;
        seen  = 0;
        if (elat > 1) begin
            check("hold_q", 32'(quotient), 32'(hold_q));
            check("hold_r", 32'(remainder), 32'(hold_r));
        end
        while (lat <= 40) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nbusy++;
            tick();
            lat++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(elat));
        check("busy_cycles", 32'(nbusy), 32'(ebusy));
        check("busy_at_done", 32'(busy), 32'd0);
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_zero", 32'(div_zero), 32'(ez));
        tick();
        check("done_pulse", 32'(done), 32'd0);
        hold_q = eq;
        hold_r = er;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, dlat, last;
        logic [DVD_W-1:0] a;
        logic [DVS_W-1:0] b;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        rst = 1'b0;
        tick();

        do_op(16'd1000, 8'd7);
        do_op(16'hFFFF, 8'hFF);
        do_op(16'd5, 8'd9);
        do_op(16'h1234, 8'd0);

        // Start pulsed mid-run must be ignored.
        start = 1'b1; dividend = 16'd100; divisor = 8'd3;
        tick();
        start = 1'b0;
        ndone = 0; dlat = 0;
        for (int s = 1; s <= 40; s++) begin
            if (s == 5) begin
                start = 1'b1; dividend = 16'd50; divisor = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    dlat = s;
                    check("ign_q", 32'(quotient), 32'd33);
                    check("ign_r", 32'(remainder), 32'd1);
                end
            end
            tick();
        end
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_latency", 32'(dlat), 32'd17);
        hold_q = 16'd33; hold_r = 8'd1;

        // Asynchronous reset in the middle of a run.
        start = 1'b1; dividend = 16'd200; divisor = 8'd9;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_q", 32'(quotient), 32'd0);
        check("arst_r", 32'(remainder), 32'd0);
        check("arst_dz", 32'(div_zero), 32'd0);
        tick(); tick();
        rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            if (done) ndone++;
            tick();
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        hold_q = '0; hold_r = '0;
        do_op(16'd200, 8'd9);

        // Back-to-back with start held high.
        start = 1'b1; dividend = 16'd60000; divisor = 8'd250;
        tick();
        ndone = 0; last = 0;
        for (int s = 1; s <= 100; s++) begin
            if (done) begin
                ndone++;
                check("b2b_interval", 32'(s - last), 32'd17);
                check("b2b_q", 32'(quotient), 32'd240);
                check("b2b_r", 32'(remainder), 32'd0);
                last = s;
                if (ndone == 5) begin
                    start = 1'b0;
                    break;
                end
            end
            tick();
        end
        check("b2b_count", 32'(ndone), 32'd5);
        tick();
        check("b2b_done_low", 32'(done), 32'd0);
        hold_q = 16'd240; hold_r = 8'd0;

        for (int i = 0; i < 2500; i++) begin
            a = DVD_W'($urandom);
            b = DVS_W'($urandom);
            case ($urandom_range(0, 15))
                0: b = '0;
                1: b = 8'd1;
                2: b = '1;
                3: a = '1;
                4: a = '0;
                default: ;
            endcase
            do_op(a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
